vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised VGA raster timing generator with a configurable pixel-request lookahead.
//  Issues 0-based pixel requests (x,y) LOOKAHEAD cycles before that pixel is driven on o_rgb,
//  so renderers/framebuffers with any fixed pipeline latency can be fed.
//  Sits between the pixel source (renderer/frame buffer) and the VGA DAC pins; runs in the pixel clock domain.
// PARAMETERS
//  H_ACTIVE  1600  visible pixels per line
//  H_FP      24    horizontal front porch (cycles)
//  H_SYNC    80    horizontal sync width (cycles)
//  H_BP      96    horizontal back porch (cycles)
//  V_ACTIVE  900   visible lines per frame
//  V_FP      1     vertical front porch (lines)
//  V_SYNC    3     vertical sync width (lines)
//  V_BP      96    vertical back porch (lines)
//  H_POL     1     hsync active level (1=active high)
//  V_POL     1     vsync active level
//  LOOKAHEAD 3     cycles from o_req to o_rgb of same pixel; legal 1..H_TOTAL
//  CW        24    colour width
//  XW        12    x/h counter width, must hold H_TOTAL-1
//  YW        11    y/v counter width, must hold V_TOTAL-1
// PORTS
//  i_clk          in   1   pixel clock
//  i_rst_n        in   1   asynchronous active-low reset
//  i_en           in   1   run enable; low = synchronous restart/hold
//  i_color        in   CW  colour of requested pixel, sampled LOOKAHEAD-1 cycles after its o_req
//  o_req_x        out  XW  requested pixel x (0-based)
//  o_req_y        out  YW  requested pixel y (0-based)
//  o_req_valid    out  1   o_req_x/y is a visible pixel
//  o_hsync        out  1   horizontal sync (polarity H_POL)
//  o_vsync        out  1   vertical sync (polarity V_POL)
//  o_de           out  1   o_rgb is a visible pixel
//  o_rgb          out  CW  pixel colour; 0 when o_de=0
//  o_frame_start  out  1   1-cycle pulse with the frame's first visible pixel (0,0)
//  o_line_start   out  1   1-cycle pulse with every visible line's x=0 pixel
//  o_vblank       out  1   display position in vertical blanking (v>=V_ACTIVE)
//  o_frame_cnt    out  32  frames started since reset; wraps modulo 2^32
// BEHAVIOUR
//  - H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Line order: active, FP, sync, BP.
//  - Display counter (h,v): h 0..H_TOTAL-1; on h wrap, v advances 0..V_TOTAL-1, wraps to 0.
//  - Request counter: the same raster, leading the display counter by LOOKAHEAD-1 cycles
//    (for LOOKAHEAD=1 it equals the display counter).
//  - All outputs are registered. Outputs at cycle n reflect counter state at cycle n-1.
//  - hsync active when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
//    vsync active on whole lines V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC.
//  - o_de = (h<H_ACTIVE && v<V_ACTIVE). o_rgb = i_color sampled on the same edge when o_de goes/stays 1, else 0.
//  - o_req_valid=1 iff the request position is visible. Contract: o_req(x,y) at cycle t => o_de/o_rgb for (x,y) at cycle t+LOOKAHEAD.
//  - o_frame_cnt increments on the edge where o_frame_start asserts, so it reads 1 during the first frame.
//  - Reset (async) or i_en=0 (sync, next edge):
//    - display counter = (0,V_ACTIVE) (start of vertical FP); request counter = that position + LOOKAHEAD-1.
//    - outputs: sync inactive (~POL), o_de=0, o_rgb=0, o_req_*=0, pulses 0, o_vblank=0.
//    - o_frame_cnt=0 on reset only; held while i_en=0.
//    - No partial frame is ever emitted; first visible frame starts after V_TOTAL-V_ACTIVE blank lines.
//  - i_en rising: sequence restarts exactly as after reset release.
//  - Reset mid-frame: outputs go to reset values immediately (async), no glitch pulses after release.
// TESTING  (small config: H 8/2/3/2 => H_TOTAL=15, V 4/1/2/1 => V_TOTAL=8, LOOKAHEAD=3, H_POL=V_POL=0)
//  1 Release reset at cycle 0 -> o_req (0,0) valid at cycle 58; o_de=1, o_frame_start=1, o_frame_cnt=1 at cycle 61.
//  2 Drive i_color=x+16*y per request (2-cycle delay model) -> every o_rgb equals its (x,y) code, 32 pixels/frame, o_rgb=0 elsewhere.
//  3 Sync check -> o_hsync low exactly 3 cycles/line at h=10..12; o_vsync low exactly 30 cycles/frame (v=5,6); period 120 cycles.
//  4 Run 3 frames -> o_frame_start once per 120 cycles, o_line_start 4 per frame, o_frame_cnt 1,2,3, o_vblank high 60 cycles/frame.
//  5 Drop i_en mid-line (v=2,h=4) for 5 cycles -> outputs at reset values next edge; after re-enable, frame_start 61 cycles later, o_frame_cnt held then +1.
//  6 Assert i_rst_n=0 mid-active -> outputs clear without clock; LOOKAHEAD=1 variant -> o_req and o_de/o_rgb same pixel 1 cycle apart.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: pixel request/colour handshake and video output bundle of the VGA timing generator
interface vga_timing_gen_if #(
  parameter int CW = 24,
  parameter int XW = 12,
  parameter int YW = 11
);
  logic [CW-1:0] i_color;
  logic [XW-1:0] o_req_x;
  logic [YW-1:0] o_req_y;
  logic          o_req_valid;
  logic          o_hsync;
  logic          o_vsync;
  logic          o_de;
  logic [CW-1:0] o_rgb;
  logic          o_frame_start;
  logic          o_line_start;
  logic          o_vblank;
  logic [31:0]   o_frame_cnt;
  modport master (
    input  i_color,
    output o_req_x, o_req_y, o_req_valid, o_hsync, o_vsync, o_de, o_rgb,
           o_frame_start, o_line_start, o_vblank, o_frame_cnt
  );
  modport slave (
    output i_color,
    input  o_req_x, o_req_y, o_req_valid, o_hsync, o_vsync, o_de, o_rgb,
           o_frame_start, o_line_start, o_vblank, o_frame_cnt
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing with pixel requests issued LOOKAHEAD cycles ahead of display
module vga_timing_gen #(
  parameter int H_ACTIVE  = 1600,
  parameter int H_FP      = 24,
  parameter int H_SYNC    = 80,
  parameter int H_BP      = 96,
  parameter int V_ACTIVE  = 900,
  parameter int V_FP      = 1,
  parameter int V_SYNC    = 3,
  parameter int V_BP      = 96,
  parameter bit H_POL     = 1'b1,
  parameter bit V_POL     = 1'b1,
  parameter int LOOKAHEAD = 3,
  parameter int CW        = 24,
  parameter int XW        = 12,
  parameter int YW        = 11
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_en,
  vga_timing_gen_if.master vga
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_ON   = H_ACTIVE + H_FP;
  localparam int HS_OFF  = HS_ON + H_SYNC;
  localparam int VS_ON   = V_ACTIVE + V_FP;
  localparam int VS_OFF  = VS_ON + V_SYNC;
  localparam logic [XW-1:0] H_LAST = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] RX_RST = XW'(LOOKAHEAD - 1);
  localparam logic [YW-1:0] V_LAST = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_VIS  = YW'(V_ACTIVE);
  logic [XW-1:0] h_q, h_d, rx_q, rx_d, req_x_q, req_x_d;
  logic [YW-1:0] v_q, v_d, ry_q, ry_d, req_y_q, req_y_d;
  logic [CW-1:0] rgb_q, rgb_d;
  logic [31:0]   fc_q, fc_d;
  logic req_v_q, req_v_d, de_q, de_d, hs_q, hs_d, vs_q, vs_d;
  logic fs_q, fs_d, ls_q, ls_d, vb_q, vb_d;
  // request outputs register the request counter's next position, so o_req leads o_de by a full LOOKAHEAD
  always_comb begin
    h_d     = (!i_en || h_q == H_LAST) ? '0 : h_q + 1'b1;
    v_d     = !i_en ? V_VIS : (h_q != H_LAST) ? v_q : (v_q == V_LAST) ? '0 : v_q + 1'b1;
    rx_d    = !i_en ? RX_RST : (rx_q == H_LAST) ? '0 : rx_q + 1'b1;
    ry_d    = !i_en ? V_VIS : (rx_q != H_LAST) ? ry_q : (ry_q == V_LAST) ? '0 : ry_q + 1'b1;
    req_x_d = i_en ? rx_d : '0;
    req_y_d = i_en ? ry_d : '0;
    req_v_d = i_en && int'(rx_d) < H_ACTIVE && int'(ry_d) < V_ACTIVE;
    de_d    = i_en && int'(h_q) < H_ACTIVE && int'(v_q) < V_ACTIVE;
    rgb_d   = de_d ? vga.i_color : '0;
    hs_d    = (i_en && int'(h_q) >= HS_ON && int'(h_q) < HS_OFF) ? H_POL : ~H_POL;
    vs_d    = (i_en && int'(v_q) >= VS_ON && int'(v_q) < VS_OFF) ? V_POL : ~V_POL;
    fs_d    = i_en && h_q == '0 && v_q == '0;
    ls_d    = i_en && h_q == '0 && int'(v_q) < V_ACTIVE;
    vb_d    = i_en && int'(v_q) >= V_ACTIVE;
    fc_d    = fc_q + 32'(fs_d);
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h_q     <= '0;
      v_q     <= V_VIS;
      rx_q    <= RX_RST;
      ry_q    <= V_VIS;
      req_x_q <= '0;
      req_y_q <= '0;
      req_v_q <= 1'b0;
      de_q    <= 1'b0;
      rgb_q   <= '0;
      hs_q    <= ~H_POL;
      vs_q    <= ~V_POL;
      fs_q    <= 1'b0;
      ls_q    <= 1'b0;
      vb_q    <= 1'b0;
      fc_q    <= '0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      rx_q    <= rx_d;
      ry_q    <= ry_d;
      req_x_q <= req_x_d;
      req_y_q <= req_y_d;
      req_v_q <= req_v_d;
      de_q    <= de_d;
      rgb_q   <= rgb_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      fs_q    <= fs_d;
      ls_q    <= ls_d;
      vb_q    <= vb_d;
      fc_q    <= fc_d;
    end
  end
  assign vga.o_req_x       = req_x_q;
  assign vga.o_req_y       = req_y_q;
  assign vga.o_req_valid   = req_v_q;
  assign vga.o_de          = de_q;
  assign vga.o_rgb         = rgb_q;
  assign vga.o_hsync       = hs_q;
  assign vga.o_vsync       = vs_q;
  assign vga.o_frame_start = fs_q;
  assign vga.o_line_start  = ls_q;
  assign vga.o_vblank      = vb_q;
  assign vga.o_frame_cnt   = fc_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: small-raster bench (15x8 total, 8x4 visible) with a request/pixel scoreboard
module tb_vga_timing_gen;
  localparam int CW = 8, XW = 4, YW = 3;
  typedef struct { int t; logic [XW-1:0] x; logic [YW-1:0] y; } req_t;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  int checks = 0, errors = 0, cyc;
  logic [7:0] d0 = 8'hAA, d1 = 8'hAA;
  req_t q[$];
  vga_timing_gen_if #(.CW(CW), .XW(XW), .YW(YW)) if0 ();
  vga_timing_gen_if #(.CW(CW), .XW(XW), .YW(YW)) if1 ();
  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0), .LOOKAHEAD(3), .CW(CW), .XW(XW), .YW(YW))
    u0 (.i_clk(clk), .i_rst_n(rst_n), .i_en(en), .vga(if0));
  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0), .LOOKAHEAD(1), .CW(CW), .XW(XW), .YW(YW))
    u1 (.i_clk(clk), .i_rst_n(rst_n), .i_en(en), .vga(if1));
  always #5 clk = ~clk;
  always @(posedge clk or negedge rst_n) cyc <= (!rst_n || !en) ? 0 : cyc + 1;
  function automatic logic [7:0] code(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return 8'({y, x});
  endfunction
  // renderer model with 2 cycles of latency for the LOOKAHEAD=3 instance
  always @(posedge clk) begin
    #1;
    if0.i_color = d1;
    d1 = d0;
    d0 = if0.o_req_valid ? code(if0.o_req_x, if0.o_req_y) : 8'hAA;
  end
  assign if1.i_color = if1.o_req_valid ? code(if1.o_req_x, if1.o_req_y) : 8'hAA;

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({if0.o_hsync, if0.o_vsync, if0.o_de, if0.o_req_valid, if0.o_frame_start, if0.o_line_start, if0.o_vblank} !== 7'b1100000) begin
      errors++;
      $display("FAIL reset_flags got %b%b%b%b%b%b%b want 1100000", if0.o_hsync, if0.o_vsync, if0.o_de,
               if0.o_req_valid, if0.o_frame_start, if0.o_line_start, if0.o_vblank);
    end
    checks++;
    if (if0.o_rgb !== 8'd0 || if0.o_req_x !== 4'd0 || if0.o_req_y !== 3'd0) begin
      errors++;
      $display("FAIL reset_data got rgb=%h x=%0d y=%0d want 0 0 0", if0.o_rgb, if0.o_req_x, if0.o_req_y);
    end
    checks++;
    if (if0.o_frame_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_frame_cnt got %0d want 0", if0.o_frame_cnt);
    end
  endtask

  task automatic test_startup();
    int n = 0;
    rst_n = 1'b1;
    do begin @(negedge clk); n++; end while (!if0.o_req_valid && n < 200);
    checks++;
    if (cyc !== 58 || if0.o_req_x !== 4'd0 || if0.o_req_y !== 3'd0) begin
      errors++;
      $display("FAIL first_req got cyc=%0d (%0d,%0d) want cyc=58 (0,0)", cyc, if0.o_req_x, if0.o_req_y);
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!if0.o_de && n < 200);
    checks++;
    if (cyc !== 61 || if0.o_frame_start !== 1'b1 || if0.o_frame_cnt !== 32'd1) begin
      errors++;
      $display("FAIL first_pixel got cyc=%0d fs=%b cnt=%0d want cyc=61 fs=1 cnt=1", cyc, if0.o_frame_start, if0.o_frame_cnt);
    end
  endtask

  task automatic test_pixels();
    int de_cnt = 0;
    req_t e;
    @(negedge clk) en = 1'b0;
    @(negedge clk) en = 1'b1;
    q.delete();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (if0.o_req_valid) q.push_back('{cyc, if0.o_req_x, if0.o_req_y});
      checks++;
      if (if0.o_de) begin
        de_cnt++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL pixel_unexpected got de at cyc=%0d want no pending request", cyc);
        end else begin
          e = q.pop_front();
          if (cyc !== e.t + 3 || if0.o_rgb !== code(e.x, e.y)) begin
            errors++;
            $display("FAIL pixel got cyc=%0d rgb=%h want cyc=%0d rgb=%h", cyc, if0.o_rgb, e.t + 3, code(e.x, e.y));
          end
        end
      end else if (if0.o_rgb !== 8'd0) begin
        errors++;
        $display("FAIL rgb_blank got %h want 00 at cyc=%0d", if0.o_rgb, cyc);
      end
    end
    checks++;
    if (de_cnt !== 64 || q.size() !== 3) begin
      errors++;
      $display("FAIL pixel_count got de=%0d pending=%0d want 64 3", de_cnt, q.size());
    end
  endtask

  task automatic test_sync();
    int n = 0, hl = 0, vl = 0, h, v;
    logic [5:0] exp;
    while (!if0.o_frame_start && n < 200) begin @(negedge clk); n++; end
    for (int k = 0; k < 120; k++) begin
      if (k > 0) @(negedge clk);
      h = k % 15;
      v = k / 15;
      exp = {!(h >= 10 && h < 13), !(v == 5 || v == 6), v >= 4, h < 8 && v < 4, h == 0 && v < 4, k == 0};
      hl += !if0.o_hsync;
      vl += !if0.o_vsync;
      checks++;
      if ({if0.o_hsync, if0.o_vsync, if0.o_vblank, if0.o_de, if0.o_line_start, if0.o_frame_start} !== exp) begin
        errors++;
        $display("FAIL timing h=%0d v=%0d got %b%b%b%b%b%b want %b", h, v, if0.o_hsync, if0.o_vsync, if0.o_vblank,
                 if0.o_de, if0.o_line_start, if0.o_frame_start, exp);
      end
    end
    checks++;
    if (hl !== 24 || vl !== 30) begin
      errors++;
      $display("FAIL sync_len got hs_low=%0d vs_low=%0d want 24 30", hl, vl);
    end
    @(negedge clk);
    checks++;
    if (if0.o_frame_start !== 1'b1) begin
      errors++;
      $display("FAIL frame_period got fs=%b want 1 after 120 cycles", if0.o_frame_start);
    end
  endtask

  task automatic test_frames();
    int n = 0, fs = 0, ls = 0, vb = 0;
    logic [31:0] fc0;
    while (!if0.o_frame_start && n < 200) begin @(negedge clk); n++; end
    fc0 = if0.o_frame_cnt;
    for (int k = 0; k < 360; k++) begin
      if (k > 0) @(negedge clk);
      ls += if0.o_line_start;
      vb += if0.o_vblank;
      if (if0.o_frame_start) begin
        checks++;
        if (k !== 120 * fs || if0.o_frame_cnt !== fc0 + 32'(fs)) begin
          errors++;
          $display("FAIL frame_start got k=%0d cnt=%0d want k=%0d cnt=%0d", k, if0.o_frame_cnt, 120 * fs, fc0 + 32'(fs));
        end
        fs++;
      end
    end
    checks++;
    if (fs !== 3 || ls !== 12 || vb !== 180) begin
      errors++;
      $display("FAIL frame_counts got fs=%0d ls=%0d vb=%0d want 3 12 180", fs, ls, vb);
    end
  endtask

  task automatic test_enable();
    int n = 0, de = 0;
    logic [31:0] fc;
    while (!if0.o_frame_start && n < 200) begin @(negedge clk); n++; end
    repeat (34) @(negedge clk);
    fc = if0.o_frame_cnt;
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({if0.o_hsync, if0.o_vsync, if0.o_de, if0.o_req_valid, if0.o_frame_start, if0.o_line_start, if0.o_vblank} !== 7'b1100000
          || if0.o_rgb !== 8'd0 || if0.o_req_x !== 4'd0 || if0.o_req_y !== 3'd0 || if0.o_frame_cnt !== fc) begin
        errors++;
        $display("FAIL disabled got flags=%b%b%b%b%b%b%b rgb=%h cnt=%0d want 1100000 00 %0d", if0.o_hsync, if0.o_vsync,
                 if0.o_de, if0.o_req_valid, if0.o_frame_start, if0.o_line_start, if0.o_vblank, if0.o_rgb, if0.o_frame_cnt, fc);
      end
    end
    en = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; de += (if0.o_de && !if0.o_frame_start); end while (!if0.o_frame_start && n < 200);
    checks++;
    if (cyc !== 61 || if0.o_frame_cnt !== fc + 32'd1 || de !== 0) begin
      errors++;
      $display("FAIL reenable got cyc=%0d cnt=%0d early_de=%0d want 61 %0d 0", cyc, if0.o_frame_cnt, de, fc + 32'd1);
    end
  endtask

  task automatic test_async_reset();
    int n = 0;
    while (!if0.o_de && n < 200) begin @(negedge clk); n++; end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({if0.o_hsync, if0.o_vsync, if0.o_de, if0.o_req_valid, if0.o_frame_start, if0.o_line_start, if0.o_vblank} !== 7'b1100000
        || if0.o_rgb !== 8'd0 || if0.o_frame_cnt !== 32'd0) begin
      errors++;
      $display("FAIL async_reset got flags=%b%b%b%b%b%b%b rgb=%h cnt=%0d want 1100000 00 0", if0.o_hsync, if0.o_vsync,
               if0.o_de, if0.o_req_valid, if0.o_frame_start, if0.o_line_start, if0.o_vblank, if0.o_rgb, if0.o_frame_cnt);
    end
    checks++;
    if (if1.o_de !== 1'b0 || if1.o_req_valid !== 1'b0 || if1.o_frame_cnt !== 32'd0) begin
      errors++;
      $display("FAIL async_reset_la1 got de=%b req=%b cnt=%0d want 0 0 0", if1.o_de, if1.o_req_valid, if1.o_frame_cnt);
    end
  endtask

  task automatic test_la1();
    int first = -1, de_cnt = 0;
    req_t e;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    for (int i = 0; i < 180; i++) begin
      @(negedge clk);
      if (if1.o_req_valid) begin
        if (first < 0) first = cyc;
        q.push_back('{cyc, if1.o_req_x, if1.o_req_y});
      end
      if (if1.o_de) begin
        de_cnt++;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL la1_unexpected got de at cyc=%0d want no pending request", cyc);
        end else begin
          e = q.pop_front();
          if (cyc !== e.t + 1 || if1.o_rgb !== code(e.x, e.y)) begin
            errors++;
            $display("FAIL la1_pixel got cyc=%0d rgb=%h want cyc=%0d rgb=%h", cyc, if1.o_rgb, e.t + 1, code(e.x, e.y));
          end
        end
      end
    end
    checks++;
    if (first !== 60 || de_cnt !== 32) begin
      errors++;
      $display("FAIL la1_counts got first_req=%0d de=%0d want 60 32", first, de_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_pixels();
    test_sync();
    test_frames();
    test_enable();
    test_async_reset();
    test_la1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
